// File: rtl/multicyc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicyc_ctrl_fsm
//
// Multi-cycle control unit for the MIPS multi-cycle core. It sequences each
// instruction through fetch, decode and execute steps and drives every
// datapath enable and select. It supports R-type, lw, sw, beq, j and addi.
// Memory accesses wait on a variable-latency mem_ready handshake, with an
// optional timeout. Funct decode for R-type lives in alu_cu; this block only
// emits aluop = funct-decode.
//
// Parameters:
//   ALUOP_W     width of aluop (0 = add, 1 = sub, 2 = funct-decode)
//   MEM_TIMEOUT max wait cycles for mem_ready; 0 waits forever
//   TO_W        width of the wait counter (must hold MEM_TIMEOUT)
//   CNT_W       width of the performance counters
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   op              instr[31:26] from IR
//   zero            ALU zero flag, sampled in BRANCH
//   mem_ready       memory completes the current read/write this cycle
//   mem_addr_sel    0 = pc, 1 = aluout_reg
//   ir_we, pc_we    instruction register / PC write enables
//   alu_srca_sel    0 = pc, 1 = rs
//   alu_srcb_sel    0 = rt, 1 = 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
//   aluop           ALU operation class
//   mem_rd, mem_wr  memory read / write requests
//   reg_we          register file write
//   nxt_pc_sel      0 = aluout, 1 = aluout_reg, 2 = jump target
//   wreg_dst_sel    0 = rt, 1 = rd
//   wrbck_data_sel  0 = aluout_reg, 1 = mdr
//   fault           sticky: illegal opcode or memory timeout
//   state_debug     current state encoding:
//                     0 IDLE, 1 FETCH, 2 DECODE, 3 MEMADR, 4 MEMRD, 5 MEMWB,
//                     6 MEMWR, 7 EXEC, 8 ALUWB, 9 BRANCH, 10 JUMP,
//                     11 ADDIEX, 12 ADDIWB, 13 ERROR
//   cyc_cnt, instr_cnt, stall_cnt
//                   performance counters, present only when the macro
//                   MULTICYC_PERF_CNT_EN is defined; tied to 0 otherwise
// -----------------------------------------------------------------------------
module multicyc_ctrl_fsm #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_addr_sel,
  output logic               ir_we,
  output logic               alu_srca_sel,
  output logic [1:0]         alu_srcb_sel,
  output logic [ALUOP_W-1:0] aluop,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               reg_we,
  output logic               pc_we,
  output logic [1:0]         nxt_pc_sel,
  output logic               wreg_dst_sel,
  output logic               wrbck_data_sel,
  output logic               fault,
  output logic [3:0]         state_debug,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   instr_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_ERROR  = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

  // The counter holds the number of wait cycles already spent, so the
  // timeout fires on the wait cycle that would bring it to MEM_TIMEOUT.
  localparam bit              TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t          state, state_nxt;
  logic [TO_W-1:0] wait_cnt;
  logic            in_wait;
  logic            timeout;

  // States that park on the memory handshake.
  assign in_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout = TO_EN && in_wait && !mem_ready && (wait_cnt == TO_LAST);

  // NOTE: state flops use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Outside the wait states the counter sits at 0, which gives the clear on
  // entry; mem_ready also clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    wait_cnt <= '0;
    else if (in_wait && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
    else                          wait_cnt <= '0;
  end

  always_comb begin
    // NOTE: every output and the next state take a default before the case,
    // so no path through it can infer a latch.
    state_nxt      = state;
    mem_addr_sel   = 1'b0;
    ir_we          = 1'b0;
    alu_srca_sel   = 1'b0;
    alu_srcb_sel   = 2'd0;
    aluop          = ALU_ADD;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    reg_we         = 1'b0;
    pc_we          = 1'b0;
    nxt_pc_sel     = 2'd0;
    wreg_dst_sel   = 1'b0;
    wrbck_data_sel = 1'b0;
    fault          = 1'b0;

    case (state)
      S_IDLE: state_nxt = S_FETCH;

      S_FETCH: begin
        mem_rd       = 1'b1;
        alu_srcb_sel = 2'd1;
        // IR and PC load in the same cycle the memory returns the word.
        ir_we        = mem_ready;
        pc_we        = mem_ready;
        if (mem_ready)    state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_ERROR;
      end

      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        alu_srcb_sel = 2'd3;
        case (op)
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDIEX;
          default:      state_nxt = S_ERROR;
        endcase
      end

      S_MEMADR: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = 2'd2;
        state_nxt    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_rd       = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready)    state_nxt = S_MEMWB;
        else if (timeout) state_nxt = S_ERROR;
      end

      S_MEMWB: begin
        reg_we         = 1'b1;
        wrbck_data_sel = 1'b1;
        state_nxt      = S_FETCH;
      end

      S_MEMWR: begin
        mem_wr       = 1'b1;
        mem_addr_sel = 1'b1;
        if (mem_ready)    state_nxt = S_FETCH;
        else if (timeout) state_nxt = S_ERROR;
      end

      S_EXEC: begin
        alu_srca_sel = 1'b1;
        aluop        = ALU_FUNCT;
        state_nxt    = S_ALUWB;
      end

      S_ALUWB: begin
        reg_we       = 1'b1;
        wreg_dst_sel = 1'b1;
        state_nxt    = S_FETCH;
      end

      S_BRANCH: begin
        alu_srca_sel = 1'b1;
        aluop        = ALU_SUB;
        nxt_pc_sel   = 2'd1;
        pc_we        = zero;
        state_nxt    = S_FETCH;
      end

      S_JUMP: begin
        pc_we      = 1'b1;
        nxt_pc_sel = 2'd2;
        state_nxt  = S_FETCH;
      end

      S_ADDIEX: begin
        alu_srca_sel = 1'b1;
        alu_srcb_sel = 2'd2;
        state_nxt    = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_we    = 1'b1;
        state_nxt = S_FETCH;
      end

      // ERROR is absorbing; only reset leaves it, which makes fault sticky.
      S_ERROR: fault = 1'b1;

      // Unused encodings are treated as a fault.
      default: state_nxt = S_ERROR;
    endcase
  end

  assign state_debug = state;

`ifdef MULTICYC_PERF_CNT_EN
  // All three counters freeze once the controller has faulted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else if (state != S_ERROR) begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (state == S_FETCH && mem_ready) instr_cnt <= instr_cnt + 1'b1;
      if (in_wait && !mem_ready)         stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign cyc_cnt   = '0;
  assign instr_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_multicyc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicyc_ctrl_fsm
//
// Self-checking bench for multicyc_ctrl_fsm built with MEM_TIMEOUT = 4.
// Phase 1 applies a directed vector table: R-type, lw with memory waits, beq
// taken/not taken, j, addi, sw, an illegal opcode, a FETCH timeout, and a
// reset asserted during MEMWR.
// Phase 2 drives random opcodes, mem_ready, zero and occasional resets. It
// compares every output against a reference model. The model tracks the
// instruction as a list of remaining steps and counts memory waits directly.
// -----------------------------------------------------------------------------
module tb_multicyc_ctrl_fsm;

  localparam int TO = 4;
`ifdef MULTICYC_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // State numbering as exposed on state_debug.
  localparam logic [3:0] IDLE = 4'd0,  FETCH = 4'd1,  DECODE = 4'd2, MEMADR = 4'd3,
                         MEMRD = 4'd4, MEMWB = 4'd5,  MEMWR = 4'd6,  EXEC = 4'd7,
                         ALUWB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10,  ADDIEX = 4'd11,
                         ADDIWB = 4'd12, ERROR = 4'd13;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04,
                         OP_J = 6'h02, OP_ADDI = 6'h08, OP_BAD = 6'h3f;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic        zero, mem_ready;
  logic        mem_addr_sel, ir_we, alu_srca_sel, mem_rd, mem_wr, reg_we, pc_we;
  logic        wreg_dst_sel, wrbck_data_sel, fault;
  logic [1:0]  alu_srcb_sel, nxt_pc_sel;
  logic [3:0]  aluop, state_debug;
  logic [31:0] cyc_cnt, instr_cnt, stall_cnt;

  multicyc_ctrl_fsm #(
    .ALUOP_W(4), .MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .alu_srca_sel(alu_srca_sel),
    .alu_srcb_sel(alu_srcb_sel), .aluop(aluop), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_we(reg_we), .pc_we(pc_we), .nxt_pc_sel(nxt_pc_sel),
    .wreg_dst_sel(wreg_dst_sel), .wrbck_data_sel(wrbck_data_sel), .fault(fault),
    .state_debug(state_debug), .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table. The ctl field packs
  // {mem_rd, mem_wr, ir_we, pc_we, reg_we, nxt_pc_sel[1:0], wreg_dst_sel,
  //  wrbck_data_sel, fault}.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         rst;
    logic [5:0] op;
    logic       z;
    logic       mr;
    logic [3:0] st;
    logic [9:0] ctl;
  } vec_t;

  vec_t vq[$];

  localparam logic [9:0] C_NONE   = 10'b0000000000;
  localparam logic [9:0] C_FETCH1 = 10'b1011000000;
  localparam logic [9:0] C_FETCH0 = 10'b1000000000;
  localparam logic [9:0] C_MEMRD  = 10'b1000000000;
  localparam logic [9:0] C_MEMWR  = 10'b0100000000;
  localparam logic [9:0] C_ALUWB  = 10'b0000100100;
  localparam logic [9:0] C_MEMWB  = 10'b0000100010;
  localparam logic [9:0] C_ADDIWB = 10'b0000100000;
  localparam logic [9:0] C_BR_T   = 10'b0001001000;
  localparam logic [9:0] C_BR_N   = 10'b0000001000;
  localparam logic [9:0] C_JUMP   = 10'b0001010000;
  localparam logic [9:0] C_ERR    = 10'b0000000001;

  task automatic add(input bit rst, input logic [5:0] o, input logic z, input logic mr,
                     input logic [3:0] st, input logic [9:0] ctl);
    vq.push_back('{rst, o, z, mr, st, ctl});
  endtask

  task automatic build_table();
    // Reset, then R-type with zero-wait memory.
    add(1, OP_R,    0, 1, IDLE,   C_NONE);
    add(0, OP_R,    0, 1, IDLE,   C_NONE);
    add(0, OP_R,    0, 1, FETCH,  C_FETCH1);
    add(0, OP_R,    0, 1, DECODE, C_NONE);
    add(0, OP_R,    0, 1, EXEC,   C_NONE);
    add(0, OP_R,    0, 1, ALUWB,  C_ALUWB);
    // lw with three wait cycles in MEMRD.
    add(0, OP_LW,   0, 1, FETCH,  C_FETCH1);
    add(0, OP_LW,   0, 1, DECODE, C_NONE);
    add(0, OP_LW,   0, 1, MEMADR, C_NONE);
    add(0, OP_LW,   0, 0, MEMRD,  C_MEMRD);
    add(0, OP_LW,   0, 0, MEMRD,  C_MEMRD);
    add(0, OP_LW,   0, 0, MEMRD,  C_MEMRD);
    add(0, OP_LW,   0, 1, MEMRD,  C_MEMRD);
    add(0, OP_LW,   0, 1, MEMWB,  C_MEMWB);
    // beq taken, then not taken.
    add(0, OP_BEQ,  1, 1, FETCH,  C_FETCH1);
    add(0, OP_BEQ,  1, 1, DECODE, C_NONE);
    add(0, OP_BEQ,  1, 1, BRANCH, C_BR_T);
    add(0, OP_BEQ,  0, 1, FETCH,  C_FETCH1);
    add(0, OP_BEQ,  0, 1, DECODE, C_NONE);
    add(0, OP_BEQ,  0, 1, BRANCH, C_BR_N);
    // j.
    add(0, OP_J,    0, 1, FETCH,  C_FETCH1);
    add(0, OP_J,    0, 1, DECODE, C_NONE);
    add(0, OP_J,    0, 1, JUMP,   C_JUMP);
    // addi.
    add(0, OP_ADDI, 0, 1, FETCH,  C_FETCH1);
    add(0, OP_ADDI, 0, 1, DECODE, C_NONE);
    add(0, OP_ADDI, 0, 1, ADDIEX, C_NONE);
    add(0, OP_ADDI, 0, 1, ADDIWB, C_ADDIWB);
    // sw with one fetch wait and one write wait.
    add(0, OP_SW,   0, 0, FETCH,  C_FETCH0);
    add(0, OP_SW,   0, 1, FETCH,  C_FETCH1);
    add(0, OP_SW,   0, 1, DECODE, C_NONE);
    add(0, OP_SW,   0, 1, MEMADR, C_NONE);
    add(0, OP_SW,   0, 0, MEMWR,  C_MEMWR);
    add(0, OP_SW,   0, 1, MEMWR,  C_MEMWR);
    // Illegal opcode: ERROR is absorbing, mem_ready ignored.
    add(0, OP_BAD,  0, 1, FETCH,  C_FETCH1);
    add(0, OP_BAD,  0, 1, DECODE, C_NONE);
    add(0, OP_BAD,  0, 1, ERROR,  C_ERR);
    add(0, OP_R,    1, 1, ERROR,  C_ERR);
    add(0, OP_R,    0, 0, ERROR,  C_ERR);
    add(1, OP_R,    0, 0, IDLE,   C_NONE);
    // FETCH timeout: four wait cycles, then ERROR.
    add(0, OP_R,    0, 0, IDLE,   C_NONE);
    add(0, OP_R,    0, 0, FETCH,  C_FETCH0);
    add(0, OP_R,    0, 0, FETCH,  C_FETCH0);
    add(0, OP_R,    0, 0, FETCH,  C_FETCH0);
    add(0, OP_R,    0, 0, FETCH,  C_FETCH0);
    add(0, OP_R,    0, 0, ERROR,  C_ERR);
    add(0, OP_R,    0, 1, ERROR,  C_ERR);
    add(1, OP_R,    0, 1, IDLE,   C_NONE);
    // Reset asserted during MEMWR: mem_wr drops without a clock edge.
    add(0, OP_SW,   0, 1, IDLE,   C_NONE);
    add(0, OP_SW,   0, 1, FETCH,  C_FETCH1);
    add(0, OP_SW,   0, 1, DECODE, C_NONE);
    add(0, OP_SW,   0, 1, MEMADR, C_NONE);
    add(0, OP_SW,   0, 0, MEMWR,  C_MEMWR);
    add(1, OP_SW,   0, 0, IDLE,   C_NONE);
    add(0, OP_SW,   0, 1, IDLE,   C_NONE);
    add(0, OP_SW,   0, 1, FETCH,  C_FETCH1);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the current step, the steps left in this instruction,
  // the number of consecutive memory waits, and the three counters.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       mem_addr_sel, ir_we, alu_srca_sel;
    logic [1:0] alu_srcb_sel;
    logic [3:0] aluop;
    logic       mem_rd, mem_wr, reg_we, pc_we;
    logic [1:0] nxt_pc_sel;
    logic       wreg_dst_sel, wrbck_data_sel, fault;
    logic [3:0] st;
  } out_t;

  out_t act_out;
  assign act_out = {mem_addr_sel, ir_we, alu_srca_sel, alu_srcb_sel, aluop, mem_rd, mem_wr,
                    reg_we, pc_we, nxt_pc_sel, wreg_dst_sel, wrbck_data_sel, fault, state_debug};

  logic [9:0] act_ctl;
  assign act_ctl = {mem_rd, mem_wr, ir_we, pc_we, reg_we, nxt_pc_sel,
                    wreg_dst_sel, wrbck_data_sel, fault};

  logic [3:0]  m_st;
  logic [3:0]  m_plan[$];
  int          m_wait;
  logic [31:0] m_cyc, m_instr, m_stall;

  function automatic out_t exp_out(input logic [3:0] s, input logic mr, input logic z);
    out_t o = '0;
    o.st = s;
    case (s)
      FETCH:  begin o.mem_rd = 1; o.alu_srcb_sel = 2'd1; o.ir_we = mr; o.pc_we = mr; end
      DECODE: o.alu_srcb_sel = 2'd3;
      MEMADR: begin o.alu_srca_sel = 1; o.alu_srcb_sel = 2'd2; end
      MEMRD:  begin o.mem_rd = 1; o.mem_addr_sel = 1; end
      MEMWB:  begin o.reg_we = 1; o.wrbck_data_sel = 1; end
      MEMWR:  begin o.mem_wr = 1; o.mem_addr_sel = 1; end
      EXEC:   begin o.alu_srca_sel = 1; o.aluop = 4'd2; end
      ALUWB:  begin o.reg_we = 1; o.wreg_dst_sel = 1; end
      BRANCH: begin o.alu_srca_sel = 1; o.aluop = 4'd1; o.nxt_pc_sel = 2'd1; o.pc_we = z; end
      JUMP:   begin o.pc_we = 1; o.nxt_pc_sel = 2'd2; end
      ADDIEX: begin o.alu_srca_sel = 1; o.alu_srcb_sel = 2'd2; end
      ADDIWB: o.reg_we = 1;
      ERROR:  o.fault = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic model_reset();
    m_st = IDLE;
    m_plan.delete();
    m_wait = 0;
    m_cyc = '0; m_instr = '0; m_stall = '0;
  endtask

  function automatic logic [3:0] next_step();
    if (m_plan.size() == 0) return FETCH;
    return m_plan.pop_front();
  endfunction

  task automatic model_step(input logic [5:0] o, input logic mr);
    bit waiting = (m_st == FETCH) || (m_st == MEMRD) || (m_st == MEMWR);
    if (m_st != ERROR) begin
      m_cyc++;
      if (m_st == FETCH && mr) m_instr++;
      if (waiting && !mr)      m_stall++;
    end
    if (m_st == IDLE) begin
      m_st = FETCH;
    end else if (waiting) begin
      if (mr) begin
        m_wait = 0;
        m_st = (m_st == FETCH) ? DECODE : next_step();
      end else begin
        m_wait++;
        if (TO != 0 && m_wait == TO) m_st = ERROR;
      end
    end else if (m_st == DECODE) begin
      m_plan.delete();
      case (o)
        OP_R:    m_plan = '{EXEC, ALUWB};
        OP_LW:   m_plan = '{MEMADR, MEMRD, MEMWB};
        OP_SW:   m_plan = '{MEMADR, MEMWR};
        OP_BEQ:  m_plan = '{BRANCH};
        OP_J:    m_plan = '{JUMP};
        OP_ADDI: m_plan = '{ADDIEX, ADDIWB};
        default: m_plan = '{ERROR};
      endcase
      m_st = next_step();
    end else if (m_st != ERROR) begin
      m_st = next_step();
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " outputs"}, act_out, exp_out(m_st, mem_ready, zero));
    check({tag, " cyc_cnt"},   cyc_cnt,   PERF ? m_cyc   : 32'd0);
    check({tag, " instr_cnt"}, instr_cnt, PERF ? m_instr : 32'd0);
    check({tag, " stall_cnt"}, stall_cnt, PERF ? m_stall : 32'd0);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    if ($urandom_range(0, 39) == 0) return 6'($urandom);
    return ops[$urandom_range(0, 5)];
  endfunction

  initial begin
    reset = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
    build_table();
    @(negedge clk);

    // Phase 1: directed vectors, one per clock, checked mid low phase.
    foreach (vq[i]) begin
      reset = vq[i].rst; op = vq[i].op; zero = vq[i].z; mem_ready = vq[i].mr;
      #1;
      check($sformatf("vec%0d state", i), state_debug, vq[i].st);
      check($sformatf("vec%0d ctl", i), act_ctl, vq[i].ctl);
      @(negedge clk);
    end

    // Phase 2: random stimulus against the reference model.
    reset = 1'b1;
    #1;
    model_reset();
    compare_all("rand reset");
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ((m_st == ERROR && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        mem_ready = 1'($urandom);
        #1;
        model_reset();
        compare_all($sformatf("rand%0d reset", c));
        @(negedge clk);
        reset = 1'b0;
      end else begin
        if (m_st == IDLE || m_st == FETCH) op = pick_op();
        mem_ready = ($urandom_range(0, 9) < 7);
        zero = 1'($urandom);
        #1;
        compare_all($sformatf("rand%0d", c));
        @(posedge clk);
        model_step(op, mem_ready);
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicyc_ctrl_fsm.md
Name: multicyc_ctrl_fsm

Overview:
- Parametrised multi-cycle control unit for the MIPS multi-cycle core.
- Successor to the fixed-latency controller. Adds beq, j and addi, an explicit next-PC select, and a variable-latency memory handshake (mem_ready) with optional timeout.
- Consumes opcode and ALU zero; drives all datapath enables and selects. Pairs with alu_cu for funct decode.

Parameters:
- ALUOP_W, 4, width of aluop.
- MEM_TIMEOUT, 0, max wait cycles for mem_ready. 0 = wait forever.
- TO_W, 8, width of the wait counter. Must hold MEM_TIMEOUT.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- op  in  6  instr[31:26] from IR
- zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  memory completes current rd/wr this cycle
- mem_addr_sel  out  1  0 = pc, 1 = aluout_reg
- ir_we  out  1  instruction register write
- alu_srca_sel  out  1  0 = pc, 1 = rs
- alu_srcb_sel  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- aluop  out  ALUOP_W  0 = add, 1 = sub, 2 = funct-decode
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- reg_we  out  1  register file write
- pc_we  out  1  PC write
- nxt_pc_sel  out  2  0 = aluout, 1 = aluout_reg, 2 = {pc[31:28], instr[25:0], 2'b00}
- wreg_dst_sel  out  1  0 = rt, 1 = rd
- wrbck_data_sel  out  1  0 = aluout_reg, 1 = mdr
- fault  out  1  sticky: illegal opcode or memory timeout
- state_debug  out  4  current state encoding
- cyc_cnt  out  CNT_W  performance counter (see Optional Feature)
- instr_cnt  out  CNT_W  performance counter (see Optional Feature)
- stall_cnt  out  CNT_W  performance counter (see Optional Feature)

Behaviour:
- reset asserted (async):
  - state = IDLE, wait counter = 0, fault = 0, counters = 0.
  - All outputs 0.
- IDLE: all outputs 0; next state FETCH.
- FETCH:
  - Outputs: mem_rd = 1, mem_addr_sel = 0, alu_srca_sel = 0, alu_srcb_sel = 1, aluop = add, nxt_pc_sel = 0.
  - ir_we and pc_we = mem_ready (same-cycle, Mealy).
  - Next state: DECODE on mem_ready, else stay.
- DECODE: alu_srca_sel = 0, alu_srcb_sel = 3, aluop = add (precomputes branch target). Next state by op:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - any other -> ERROR
- MEMADR: srca = 1, srcb = 2, add. Next: MEMRD if lw, MEMWR if sw.
- MEMRD: mem_rd = 1, mem_addr_sel = 1. Next: MEMWB on mem_ready, else stay.
- MEMWB: reg_we = 1, wreg_dst_sel = 0, wrbck_data_sel = 1. Next: FETCH.
- MEMWR: mem_wr = 1, mem_addr_sel = 1. Next: FETCH on mem_ready, else stay. mem_wr held stable until mem_ready.
- EXEC: srca = 1, srcb = 0, aluop = funct. Next: ALUWB.
- ALUWB: reg_we = 1, wreg_dst_sel = 1, wrbck_data_sel = 0. Next: FETCH.
- BRANCH: srca = 1, srcb = 0, aluop = sub, nxt_pc_sel = 1, pc_we = zero. Next: FETCH.
- JUMP: pc_we = 1, nxt_pc_sel = 2. Next: FETCH.
- ADDIEX: srca = 1, srcb = 2, add. Next: ADDIWB.
- ADDIWB: reg_we = 1, wreg_dst_sel = 0, wrbck_data_sel = 0. Next: FETCH.
- ERROR:
  - fault = 1, all enables 0.
  - Absorbing; left only by reset.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR, and whenever mem_ready = 1.
  - Increments each cycle in those states while mem_ready = 0.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with mem_ready still 0, next state is ERROR.
  - mem_ready = 1 on the timeout cycle wins: normal transition.
- mem_ready outside FETCH, MEMRD or MEMWR is ignored.
- Unspecified outputs in a state are 0.
- Cycles per instruction with zero-wait memory:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each wait cycle adds 1.
- Reset asserted mid-instruction: state returns to IDLE immediately, and no enable is asserted in the following cycle.

Optional Feature:
- Macro: MULTICYC_PERF_CNT_EN.
- Defined:
  - cyc_cnt increments every cycle out of reset.
  - instr_cnt increments on each FETCH with mem_ready = 1.
  - stall_cnt increments on each cycle in FETCH, MEMRD or MEMWR with mem_ready = 0.
  - All three wrap at 2^CNT_W and freeze in ERROR.
- Undefined: the three ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset, then add R-type (op = 0), mem_ready tied 1: states IDLE, FETCH, DECODE, EXEC, ALUWB, FETCH. reg_we = 1 only in ALUWB with wreg_dst_sel = 1.
- lw with mem_ready low 3 cycles in MEMRD: mem_rd held 4 cycles, MEMWB reached; with MULTICYC_PERF_CNT_EN, stall_cnt = 3 and instr_cnt = 1.
- beq: zero = 1 gives pc_we = 1 with nxt_pc_sel = 1; zero = 0 gives pc_we = 0. Both return to FETCH after 3 cycles.
- j (op = 000010): pc_we = 1 and nxt_pc_sel = 2 in JUMP; next instruction fetched 3 cycles after the previous fetch.
- MEM_TIMEOUT = 4, mem_ready never asserted in FETCH: ERROR after 4 wait cycles, fault = 1 sticky, all enables 0. Reset returns to IDLE with fault = 0.
- Illegal op 111111: DECODE -> ERROR; asserting reset mid-MEMWR drops mem_wr to 0 asynchronously.
